// File: rtl/gbt_link_sequencer.sv
// GBT SFP link bring-up and recovery sequencer, 40 MHz frame clock domain.
// Waits for PLL lock, sequences MGT / GBT TX / GBT RX resets, qualifies RX
// alignment and re-runs the sequence on loss or timeout while counting retries.

typedef struct packed {
  logic clk;
  logic reset;
} ckrs_t;

module gbt_link_sequencer #(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned ALIGN_TIMEOUT = 65535,
  parameter int unsigned DEBOUNCE      = 8
) (
  input  ckrs_t       ClkRs_ix,
  input  logic        pll_locked_i,
  input  logic        mgt_tx_ready_i,
  input  logic        mgt_rx_ready_i,
  input  logic        rx_aligned_i,
  input  logic        relink_i,
  output logic        mgt_reset_o,
  output logic        tx_reset_o,
  output logic        rx_reset_o,
  output logic        link_up_o,
  output logic        link_lost_o,
  output logic [7:0]  retry_cnt_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StWaitPll   = 3'd1,
    StMgtRst    = 3'd2,
    StWaitMgt   = 3'd3,
    StWaitAlign = 3'd4,
    StLinkUp    = 3'd5
  } state_e;

  logic        clk_tree_x;
  logic        rst;
  state_e      state_q, state_d;
  logic [15:0] timer_q;
  logic [15:0] deb_q;
  logic [7:0]  retry_q;
  logic        restart;    // relink re-entry; restarts timer even when staying in MGT_RST
  logic        retry_inc;
  logic        entry;
  logic        aligned_match;
  logic        deb_done;
  logic        lost_d;
  logic        active;

  assign clk_tree_x  = ClkRs_ix.clk;
  assign rst         = ClkRs_ix.reset;
  assign state_o     = state_q;
  assign retry_cnt_o = retry_q;

  // Next-state decode: PLL loss beats relink, relink beats normal progress.
  always_comb begin
    state_d       = state_q;
    restart       = 1'b0;
    retry_inc     = 1'b0;
    active        = state_q inside {StMgtRst, StWaitMgt, StWaitAlign, StLinkUp};
    // LINK_UP awaits a low alignment, every other state awaits a high one.
    aligned_match = (state_q == StLinkUp) ? ~rx_aligned_i : rx_aligned_i;
    deb_done      = aligned_match && (deb_q == 16'(DEBOUNCE - 1));
    if (!pll_locked_i && active) begin
      state_d = StWaitPll;
    end else if (relink_i && active) begin
      state_d = StMgtRst;
      restart = 1'b1;
    end else begin
      case (state_q)
        StIdle:    state_d = StWaitPll;
        StWaitPll: if (pll_locked_i) state_d = StMgtRst;
        StMgtRst:  if (timer_q == 16'(RESET_CYCLES - 1)) state_d = StWaitMgt;
        StWaitMgt: begin
          if (mgt_tx_ready_i && mgt_rx_ready_i) begin
            state_d = StWaitAlign;
          end else if (timer_q == 16'(LOCK_TIMEOUT - 1)) begin
            state_d   = StMgtRst;
            retry_inc = 1'b1;
          end
        end
        StWaitAlign: begin
          if (deb_done) begin
            state_d = StLinkUp;
          end else if (timer_q == 16'(ALIGN_TIMEOUT - 1)) begin
            state_d   = StMgtRst;
            retry_inc = 1'b1;
          end
        end
        StLinkUp: begin
          if (!mgt_tx_ready_i || !mgt_rx_ready_i || deb_done) begin
            state_d   = StMgtRst;
            retry_inc = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    entry  = restart || (state_d != state_q);
    lost_d = (state_q == StLinkUp) && (state_d != StLinkUp) && !restart;
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk_tree_x or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      deb_q       <= '0;
      retry_q     <= '0;
      mgt_reset_o <= 1'b1;
      tx_reset_o  <= 1'b1;
      rx_reset_o  <= 1'b1;
      link_up_o   <= 1'b0;
      link_lost_o <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= entry ? '0 : timer_q + 16'd1;
      if (entry || !aligned_match) begin
        deb_q <= '0;
      end else if (deb_q != 16'hFFFF) begin
        deb_q <= deb_q + 16'd1;
      end
      if (retry_inc && (retry_q != 8'hFF)) begin
        retry_q <= retry_q + 8'd1;
      end
      mgt_reset_o <= state_d inside {StIdle, StWaitPll, StMgtRst};
      tx_reset_o  <= state_d inside {StIdle, StWaitPll, StMgtRst, StWaitMgt};
      rx_reset_o  <= state_d inside {StIdle, StWaitPll, StMgtRst, StWaitMgt};
      link_up_o   <= (state_d == StLinkUp);
      link_lost_o <= lost_d;
    end
  end

endmodule

// File: tb/tb_gbt_link_sequencer.sv
// Directed bench for gbt_link_sequencer: expected status words are queued as
// stimulus is driven and popped when the DUT output is sampled.

module tb_gbt_link_sequencer;

  localparam int unsigned RstCyc   = 16;
  localparam int unsigned LockTo   = 32;
  localparam int unsigned AlignTo  = 100;
  localparam int unsigned Deb      = 8;
  localparam int unsigned Period   = RstCyc + LockTo;

  logic       clk;
  logic       rst;
  logic [1:0] clk_rs;
  logic       pll_locked, tx_ready, rx_ready, aligned, relink;
  logic       mgt_reset, tx_reset, rx_reset, link_up, link_lost;
  logic [7:0] retry_cnt;
  logic [2:0] state;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  assign clk_rs = {clk, rst};

  gbt_link_sequencer #(
    .RESET_CYCLES (RstCyc),
    .LOCK_TIMEOUT (LockTo),
    .ALIGN_TIMEOUT(AlignTo),
    .DEBOUNCE     (Deb)
  ) dut (
    .ClkRs_ix      (clk_rs),
    .pll_locked_i  (pll_locked),
    .mgt_tx_ready_i(tx_ready),
    .mgt_rx_ready_i(rx_ready),
    .rx_aligned_i  (aligned),
    .relink_i      (relink),
    .mgt_reset_o   (mgt_reset),
    .tx_reset_o    (tx_reset),
    .rx_reset_o    (rx_reset),
    .link_up_o     (link_up),
    .link_lost_o   (link_lost),
    .retry_cnt_o   (retry_cnt),
    .state_o       (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected status word from the state decode table.
  function automatic logic [15:0] stat(input logic [2:0] st, input logic lost,
                                       input logic [7:0] retry);
    logic [3:0] mtru;
    case (st)
      3'd0, 3'd1, 3'd2: mtru = 4'b1110;
      3'd3:             mtru = 4'b0110;
      3'd4:             mtru = 4'b0000;
      3'd5:             mtru = 4'b0001;
      default:          mtru = 4'bxxxx;
    endcase
    return {st, mtru, lost, retry};
  endfunction

  task automatic push(input string tag, input logic [15:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [15:0] obs;
    obs = {state, mgt_reset, tx_reset, rx_reset, link_up, link_lost, retry_cnt};
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h, no expected entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue expectation, advance n cycles, compare.
  task automatic step(input int n, input string tag, input logic [2:0] st,
                      input logic lost, input logic [7:0] retry);
    push(tag, stat(st, lost, retry));
    tick(n);
    check();
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    tx_ready   = 1'b1;
    rx_ready   = 1'b1;
    aligned    = 1'b1;
    relink     = 1'b0;
    step(2, "reset_values", 3'd0, 1'b0, 8'd0);
    rst = 1'b0;

    // Bring-up.
    step(1, "idle_to_wait_pll", 3'd1, 1'b0, 8'd0);
    step(3, "wait_pll_hold", 3'd1, 1'b0, 8'd0);
    pll_locked = 1'b1;
    step(1, "enter_mgt_rst", 3'd2, 1'b0, 8'd0);
    step(RstCyc - 1, "mgt_rst_last_cycle", 3'd2, 1'b0, 8'd0);
    step(1, "wait_mgt", 3'd3, 1'b0, 8'd0);
    step(1, "enter_wait_align", 3'd4, 1'b0, 8'd0);
    step(Deb - 1, "wait_align_debounce", 3'd4, 1'b0, 8'd0);
    step(1, "link_up", 3'd5, 1'b0, 8'd0);

    // Short alignment glitch does not drop the link.
    aligned = 1'b0;
    step(Deb - 1, "glitch_7_low", 3'd5, 1'b0, 8'd0);
    aligned = 1'b1;
    step(1, "glitch_recovered", 3'd5, 1'b0, 8'd0);
    aligned = 1'b0;
    step(Deb - 1, "loss_7_low", 3'd5, 1'b0, 8'd0);
    step(1, "loss_debounced", 3'd2, 1'b1, 8'd1);
    aligned = 1'b1;
    step(1, "lost_single_pulse", 3'd2, 1'b0, 8'd1);
    step(RstCyc + 1 + Deb - 1, "relinked_1", 3'd5, 1'b0, 8'd1);

    // PLL loss from LINK_UP.
    pll_locked = 1'b0;
    step(1, "pll_drop", 3'd1, 1'b1, 8'd1);
    step(1, "pll_drop_pulse_end", 3'd1, 1'b0, 8'd1);
    pll_locked = 1'b1;
    step(1, "pll_back", 3'd2, 1'b0, 8'd1);
    step(RstCyc + 1 + Deb, "relinked_2", 3'd5, 1'b0, 8'd1);

    // Relink coinciding with a debounced loss.
    aligned = 1'b0;
    step(Deb - 1, "pre_relink_low", 3'd5, 1'b0, 8'd1);
    relink = 1'b1;
    step(1, "relink_wins", 3'd2, 1'b0, 8'd1);
    relink  = 1'b0;
    aligned = 1'b1;
    step(1, "relink_no_pulse", 3'd2, 1'b0, 8'd1);
    step(RstCyc + 1 + Deb - 1, "relinked_3", 3'd5, 1'b0, 8'd1);

    // MGT ready drop and lock timeout loop.
    tx_ready = 1'b0;
    step(1, "tx_ready_drop", 3'd2, 1'b1, 8'd2);
    step(RstCyc, "timeout_wait_mgt", 3'd3, 1'b0, 8'd2);
    step(LockTo - 1, "wait_mgt_last", 3'd3, 1'b0, 8'd2);
    step(1, "lock_timeout_retry", 3'd2, 1'b0, 8'd3);

    // Asynchronous reset in the middle of WAIT_ALIGN.
    tx_ready = 1'b1;
    aligned  = 1'b0;
    step(RstCyc, "to_wait_mgt", 3'd3, 1'b0, 8'd3);
    step(1, "to_wait_align", 3'd4, 1'b0, 8'd3);
    step(5, "mid_wait_align", 3'd4, 1'b0, 8'd3);
    rst = 1'b1;
    push("async_reset", stat(3'd0, 1'b0, 8'd0));
    #2;
    check();
    step(1, "reset_held", 3'd0, 1'b0, 8'd0);
    rst = 1'b0;
    step(1, "restart_wait_pll", 3'd1, 1'b0, 8'd0);
    step(1, "restart_mgt_rst", 3'd2, 1'b0, 8'd0);
    step(RstCyc + 1, "restart_wait_align", 3'd4, 1'b0, 8'd0);
    step(AlignTo - 1, "align_timeout_last", 3'd4, 1'b0, 8'd0);
    step(1, "align_timeout_retry", 3'd2, 1'b0, 8'd1);

    // Retry counter saturation.
    tx_ready = 1'b0;
    step(Period * 300, "retry_saturated", 3'd2, 1'b0, 8'd255);
    step(Period, "retry_stays_255", 3'd2, 1'b0, 8'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
